ads127l01_fsync_master_model: RTL and testbench



---
 rtl/ads127l01_fsync_master_model.sv | 106 ++++++++++
 tb/tb_ads127l01_fsync_master_model.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ads127l01_fsync_master_model.sv
// ADS127L01 frame-sync master port model: generates sck, fsync and MSB-first dout
// carrying one DATA_W-bit sample per frame, latched from din just after fsync rises.
module ads127l01_fsync_master_model #(
  parameter int unsigned SCK_HALF   = 2,
  parameter int unsigned FRAME_SCKS = 48,
  parameter int unsigned DATA_W     = 24
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic              sck,
  output logic              dout,
  output logic              fsync
);

  localparam int unsigned DivN = 2 * SCK_HALF;
  localparam int unsigned DivW = $clog2(DivN);
  localparam int unsigned IdxW = $clog2(FRAME_SCKS);

  localparam logic [DivW-1:0] DivLast = DivW'(DivN - 1);
  localparam logic [DivW-1:0] DivHalf = DivW'(SCK_HALF);
  localparam logic [DivW-1:0] DivOne  = DivW'(1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(FRAME_SCKS - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              sck_q, sck_d;
  logic              fsync_q, fsync_d;
  logic              dout_q, dout_d;
  logic              run_d;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= StIdle;
      div_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      sck_q   <= 1'b0;
      fsync_q <= 1'b0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      sck_q   <= sck_d;
      fsync_q <= fsync_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;

    unique case (state_q)
      StIdle: begin
        div_d = '0;
        idx_d = '0;
        if (en) state_d = StRun;
      end
      StRun: begin
        if (!en) begin
          // Abort immediately; a re-enable always starts a fresh frame.
          state_d = StIdle;
          div_d   = '0;
          idx_d   = '0;
        end else if (div_q == DivLast) begin
          div_d = '0;
          idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        div_d   = '0;
        idx_d   = '0;
      end
    endcase

    run_d = (state_d == StRun);

    if (run_d && (idx_d == '0) && (div_d == DivOne)) shreg_d = din;

    // Outputs are decoded from next state so they register alongside div/idx.
    sck_d   = run_d && (div_d >= DivHalf);
    fsync_d = run_d && (idx_d == '0);
    dout_d  = 1'b0;
    for (int k = 0; k < DATA_W; k++) begin
      if (run_d && (idx_d == IdxW'(DATA_W - k))) dout_d = shreg_q[k];
    end
  end

  assign sck   = sck_q;
  assign fsync = fsync_q;
  assign dout  = dout_q;

endmodule

// File: tb/tb_ads127l01_fsync_master_model.sv
// Bench for ads127l01_fsync_master_model: default and minimum-size instances checked
// every cycle against a time-based frame model, plus a serial receiver on the default one.
module tb_ads127l01_fsync_master_model;

  localparam int NI = 2;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic        en = 1'b0;
  logic [23:0] din = '0;
  logic        sck0, dout0, fsync0;
  logic        sck1, dout1, fsync1;

  always #5 aclk = ~aclk;

  ads127l01_fsync_master_model dut0 (
    .aclk    (aclk),
    .aresetn (aresetn),
    .en      (en),
    .din     (din),
    .sck     (sck0),
    .dout    (dout0),
    .fsync   (fsync0)
  );

  ads127l01_fsync_master_model #(
    .SCK_HALF   (1),
    .FRAME_SCKS (26),
    .DATA_W     (24)
  ) dut1 (
    .aclk    (aclk),
    .aresetn (aresetn),
    .en      (en),
    .din     (din),
    .sck     (sck1),
    .dout    (dout1),
    .fsync   (fsync1)
  );

  int total = 0;
  int bad = 0;

  // Reference model: time since frame-train start, per instance.
  int          sh_m   [NI];
  int          fs_m   [NI];
  bit          run_m  [NI];
  int          t_m    [NI];
  logic [23:0] word_m [NI];

  // Serial receiver on instance 0.
  logic        prev_sck = 1'b0;
  logic        prev_fs = 1'b0;
  int          rx_cnt = 99;
  logic [23:0] rx_sh = '0;
  logic [23:0] rx_word = '0;
  int          cyc = 0;
  int          last_rise = -1;
  int          last_period = 0;
  int          hcnt = 0;
  int          last_high = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] act(input int i);
    return (i == 0) ? {sck0, fsync0, dout0} : {sck1, fsync1, dout1};
  endfunction

  function automatic logic [2:0] model(input int i);
    int          per, pos, idx;
    logic        s, f, d;
    logic [23:0] w;
    per = 2 * sh_m[i] * fs_m[i];
    pos = t_m[i] % per;
    idx = pos / (2 * sh_m[i]);
    w   = word_m[i];
    s   = run_m[i] && ((pos % (2 * sh_m[i])) >= sh_m[i]);
    f   = run_m[i] && (idx == 0);
    d   = 1'b0;
    if (run_m[i] && idx >= 1 && idx <= 24) d = w[5'(24 - idx)];
    return {s, f, d};
  endfunction

  task automatic compare_all(input string tag);
    logic [2:0] a, e;
    for (int i = 0; i < NI; i++) begin
      a = act(i);
      e = model(i);
      check($sformatf("%s.i%0d.sck", tag, i), 32'(a[2]), 32'(e[2]));
      check($sformatf("%s.i%0d.fsync", tag, i), 32'(a[1]), 32'(e[1]));
      check($sformatf("%s.i%0d.dout", tag, i), 32'(a[0]), 32'(e[0]));
    end
  endtask

  task automatic step(input string tag);
    logic        en_s, rst_s;
    logic [23:0] din_s;
    int          per;
    en_s  = en;
    rst_s = aresetn;
    din_s = din;
    @(posedge aclk);
    for (int i = 0; i < NI; i++) begin
      per = 2 * sh_m[i] * fs_m[i];
      if (!rst_s || !en_s) begin
        run_m[i] = 1'b0;
        t_m[i]   = 0;
      end else if (!run_m[i]) begin
        run_m[i] = 1'b1;
        t_m[i]   = 0;
      end else begin
        t_m[i]++;
      end
      if (run_m[i] && (t_m[i] % per) == 1) word_m[i] = din_s;
    end
    #1;
    cyc++;
    if (sck0 && !prev_sck) begin
      if (fsync0) rx_cnt = 0;
      else if (rx_cnt < 24) begin
        rx_sh = {rx_sh[22:0], dout0};
        rx_cnt++;
        if (rx_cnt == 24) rx_word = rx_sh;
      end
    end
    if (fsync0 && !prev_fs) begin
      if (last_rise >= 0) last_period = cyc - last_rise;
      last_rise = cyc;
      hcnt = 0;
    end
    if (fsync0) hcnt++;
    if (!fsync0 && prev_fs) last_high = hcnt;
    prev_sck = sck0;
    prev_fs  = fsync0;
    compare_all(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  // Entered right after fsync rose on instance 0; leaves at the next fsync rise.
  task automatic frame_word(input logic [23:0] value, input string tag);
    din = value;
    run(41, tag);
    din = 24'($urandom);
    run(151, tag);
    check({tag, ".rx"}, 32'(rx_word), 32'(value));
  endtask

  initial begin
    bit found;
    sh_m = '{2, 1};
    fs_m = '{48, 26};
    for (int i = 0; i < NI; i++) begin
      run_m[i]  = 1'b0;
      t_m[i]    = 0;
      word_m[i] = '0;
    end

    #1 aresetn = 1'b0;
    #2 compare_all("reset");
    run(3, "reset_held");
    aresetn = 1'b1;
    run(2, "idle");

    // en rises: fsync one aclk later.
    en = 1'b1;
    din = 24'($urandom);
    step("start");
    check("start.fsync_lat", 32'(fsync0), 32'd1);

    frame_word(24'hA5A5A5, "a5");
    frame_word(24'h800000, "neg_fs");
    check("neg_fs.signed", 32'($signed(rx_word)), 32'(-8388608));
    frame_word(24'h7FFFFF, "pos_fs");
    check("pos_fs.signed", 32'($signed(rx_word)), 32'(8388607));
    check("fs_period", 32'(last_period), 32'd192);
    check("fs_high", 32'(last_high), 32'd4);

    // Abort at idx 12, then restart.
    din = 24'($urandom);
    run(48, "pre_abort");
    en = 1'b0;
    step("abort");
    check("abort.sck", 32'(sck0), 32'd0);
    run(3, "abort_idle");
    en = 1'b1;
    step("restart");
    check("restart.fsync", 32'(fsync0), 32'd1);
    frame_word(24'($urandom), "fresh");

    // Randomized traffic with occasional enable toggles.
    for (int k = 0; k < 1500; k++) begin
      din = 24'($urandom);
      if ($urandom_range(0, 199) == 0) en = ~en;
      step("rand");
    end
    en = 1'b1;

    // Seek idx 5 with sck high on instance 0, then assert reset mid-cycle.
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      din = 24'($urandom);
      step("seek");
      if (run_m[0] && ((t_m[0] % 192) / 4 == 5) && ((t_m[0] % 4) >= 2)) found = 1'b1;
    end
    check("seek_idx5", 32'(found), 32'd1);
    check("seek.sck_high", 32'(sck0), 32'd1);
    #2 aresetn = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      run_m[i] = 1'b0;
      t_m[i]   = 0;
    end
    compare_all("async_rst");
    run(2, "rst_held");
    aresetn = 1'b1;
    step("post_rst");
    check("post_rst.fsync", 32'(fsync0), 32'd1);
    for (int k = 0; k < 200; k++) begin
      din = 24'($urandom);
      step("post_rst_run");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
